// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I-subset control unit: Moore FSM that sequences fetch, decode,
// memory, ALU, branch and jump steps, and traps on anything it cannot decode.
module mc_control_fsm #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter bit          EXT_BRANCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_i,
  input  logic                  zero,
  input  logic                  lt_i,
  input  logic                  ltu_i,
  input  logic                  mem_ready_i,
  output logic                  PC_wr,
  output logic                  IR_wr,
  output logic                  adr_src,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  reg_wr,
  output logic [1:0]            ALU_src_a,
  output logic [1:0]            ALU_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] ALU_ctrl,
  output logic [3:0]            state_o,
  output logic                  illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b100);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b101);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(3'b110);

  state_e                  state_q, state_d, state_sel;
  logic [ALU_CTRL_W-1:0]   arith_ctrl;
  logic                    arith_legal;
  logic                    br_taken;
  logic                    br_legal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; combinational blocks below use blocking ones.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Shared funct3 -> ALU operation map for register and immediate arithmetic.
  always_comb begin
    arith_legal = 1'b1;
    arith_ctrl  = '0;
    case (funct3_i)
      3'b000:  arith_ctrl = ALU_ADD;
      3'b010:  arith_ctrl = ALU_SLT;
      3'b100:  arith_ctrl = ALU_XOR;
      3'b110:  arith_ctrl = ALU_OR;
      3'b111:  arith_ctrl = ALU_AND;
      default: arith_legal = 1'b0;
    endcase
  end

  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3_i)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt_i;
      3'b101:  br_taken = ~lt_i;
      3'b110:  br_taken = ltu_i;
      3'b111:  br_taken = ~ltu_i;
      default: br_legal = 1'b0;
    endcase
    if (funct3_i[2] && !EXT_BRANCH) br_legal = 1'b0;
    if (!br_legal) br_taken = 1'b0;
  end

  always_comb begin
    case (op_i)
      OP_I, OP_LOAD, OP_JALR: imm_src = 2'b00;
      OP_STORE:               imm_src = 2'b01;
      OP_BRANCH:              imm_src = 2'b10;
      default:                imm_src = 2'b11;
    endcase
  end

  // While rst is high the outputs show FETCH decoding without its write enables.
  assign state_sel = rst ? S_FETCH : state_q;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    PC_wr      = 1'b0;
    IR_wr      = 1'b0;
    adr_src    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    ALU_src_a  = 2'b00;
    ALU_src_b  = 2'b00;
    result_src = 2'b00;
    ALU_ctrl   = '0;
    case (state_sel)
      S_FETCH: begin
        mem_rd     = 1'b1;
        ALU_src_b  = 2'b10;
        ALU_ctrl   = ALU_ADD;
        result_src = 2'b10;
        IR_wr      = mem_ready_i & ~rst;
        PC_wr      = mem_ready_i & ~rst;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALU_src_a = 2'b01;
        ALU_src_b = 2'b01;
        ALU_ctrl  = ALU_ADD;
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        ALU_src_a = 2'b10;
        ALU_src_b = 2'b01;
        ALU_ctrl  = ALU_ADD;
        state_d   = (op_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_wr     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALU_src_a = 2'b10;
        ALU_ctrl  = (funct3_i == 3'b000 && funct7_i) ? ALU_SUB : arith_ctrl;
        state_d   = arith_legal ? S_ALU_WB : S_TRAP;
      end
      S_EXEC_I: begin
        ALU_src_a = 2'b10;
        ALU_src_b = 2'b01;
        ALU_ctrl  = arith_ctrl;
        state_d   = arith_legal ? S_ALU_WB : S_TRAP;
      end
      S_ALU_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src_a = 2'b10;
        ALU_ctrl  = ALU_SUB;
        PC_wr     = br_taken;
        state_d   = br_legal ? S_FETCH : S_TRAP;
      end
      S_JALR_ADR: begin
        ALU_src_a = 2'b10;
        ALU_src_b = 2'b01;
        ALU_ctrl  = ALU_ADD;
        state_d   = S_JAL;
      end
      S_JAL: begin
        ALU_src_a = 2'b01;
        ALU_src_b = 2'b10;
        ALU_ctrl  = ALU_ADD;
        PC_wr     = 1'b1;
        state_d   = S_ALU_WB;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign state_o   = state_q;
  assign illegal_o = (state_q == S_TRAP);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through the FSM
// with hand-computed state and control expectations, plus a no-extended-branch copy.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7_i, zero, lt_i, ltu_i, mem_ready_i;

  logic       PC_wr, IR_wr, adr_src, mem_rd, mem_wr, reg_wr, illegal_o;
  logic [1:0] ALU_src_a, ALU_src_b, result_src, imm_src;
  logic [2:0] ALU_ctrl;
  logic [3:0] state_o;

  logic       nx_PC_wr, nx_IR_wr, nx_adr_src, nx_mem_rd, nx_mem_wr, nx_reg_wr, nx_illegal;
  logic [1:0] nx_src_a, nx_src_b, nx_result_src, nx_imm_src;
  logic [3:0] nx_ALU_ctrl;
  logic [3:0] nx_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .zero(zero), .lt_i(lt_i), .ltu_i(ltu_i), .mem_ready_i(mem_ready_i),
    .PC_wr(PC_wr), .IR_wr(IR_wr), .adr_src(adr_src), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b),
    .result_src(result_src), .imm_src(imm_src), .ALU_ctrl(ALU_ctrl),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  mc_control_fsm #(.ALU_CTRL_W(4), .EXT_BRANCH(1'b0)) dut_nx (
    .clk(clk), .rst(rst), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .zero(zero), .lt_i(lt_i), .ltu_i(ltu_i), .mem_ready_i(mem_ready_i),
    .PC_wr(nx_PC_wr), .IR_wr(nx_IR_wr), .adr_src(nx_adr_src), .mem_rd(nx_mem_rd),
    .mem_wr(nx_mem_wr), .reg_wr(nx_reg_wr), .ALU_src_a(nx_src_a), .ALU_src_b(nx_src_b),
    .result_src(nx_result_src), .imm_src(nx_imm_src), .ALU_ctrl(nx_ALU_ctrl),
    .state_o(nx_state), .illegal_o(nx_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Presents an instruction in FETCH with memory ready and steps past DECODE.
  task automatic go(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_i = op; funct3_i = f3; funct7_i = f7; mem_ready_i = 1'b1;
    #1;
    check("fetch_state", state_o, 0);
    check("fetch_ir_wr", IR_wr, 1);
    check("fetch_pc_wr", PC_wr, 1);
    tick();
    check("decode_state", state_o, 1);
    check("decode_src", {ALU_src_a, ALU_src_b}, 4'b0101);
    tick();
  endtask

  // Arithmetic vectors: op, funct3, funct7, expected exec state, expected ALU_ctrl.
  logic [6:0] v_op   [6] = '{OP_R, OP_R, OP_R, OP_I, OP_I, OP_I};
  logic [2:0] v_f3   [6] = '{3'b000, 3'b100, 3'b111, 3'b000, 3'b010, 3'b110};
  logic       v_f7   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] v_st   [6] = '{4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd7};
  logic [2:0] v_alu  [6] = '{3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b010};

  initial begin
    rst = 1'b1; op_i = '0; funct3_i = '0; funct7_i = 1'b0;
    zero = 1'b0; lt_i = 1'b0; ltu_i = 1'b0; mem_ready_i = 1'b1;
    tick(); tick();

    // Held in reset: FETCH decoding with the write enables suppressed.
    check("rst_state", state_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_mem_rd", mem_rd, 1);
    check("rst_ir_wr", IR_wr, 0);
    check("rst_pc_wr", PC_wr, 0);
    check("rst_srcs", {ALU_src_a, ALU_src_b, result_src}, 6'b001010);
    check("rst_alu", ALU_ctrl, 3'b011);
    check("rst_nx_alu_zext", nx_ALU_ctrl, 4'b0011);
    rst = 1'b0;

    // add
    go(OP_R, 3'b000, 1'b0);
    check("add_exec_state", state_o, 6);
    check("add_exec_alu", ALU_ctrl, 3'b011);
    check("add_exec_reg_wr", reg_wr, 0);
    tick();
    check("add_wb_state", state_o, 8);
    check("add_wb_reg_wr", reg_wr, 1);
    tick();
    check("add_back_fetch", state_o, 0);

    for (int i = 0; i < 6; i++) begin
      go(v_op[i], v_f3[i], v_f7[i]);
      check($sformatf("arith%0d_state", i), state_o, v_st[i]);
      check($sformatf("arith%0d_alu", i), ALU_ctrl, v_alu[i]);
      tick();
      check($sformatf("arith%0d_wb", i), state_o, 8);
      tick();
    end

    // load with three wait cycles in MEM_RD
    go(OP_LOAD, 3'b010, 1'b0);
    check("ld_imm_src", imm_src, 2'b00);
    check("ld_adr_state", state_o, 2);
    check("ld_adr_srcs", {ALU_src_a, ALU_src_b}, 4'b1001);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = (i == 3);
      #1;
      check($sformatf("ld_wait%0d_state", i), state_o, 3);
      check($sformatf("ld_wait%0d_rd_adr", i), {mem_rd, adr_src}, 2'b11);
      tick();
    end
    check("ld_wb_state", state_o, 4);
    check("ld_wb_result_src", result_src, 2'b01);
    check("ld_wb_reg_wr", reg_wr, 1);
    tick();
    check("ld_back_fetch", state_o, 0);

    // bne not-equal: taken
    zero = 1'b0;
    go(OP_BRANCH, 3'b001, 1'b0);
    check("bne_state", state_o, 9);
    check("bne_pc_wr", PC_wr, 1);
    check("bne_alu_sub", ALU_ctrl, 3'b100);
    check("bne_imm_src", imm_src, 2'b10);
    tick();
    check("bne_back_fetch", state_o, 0);

    // bge with lt: not taken
    lt_i = 1'b1;
    go(OP_BRANCH, 3'b101, 1'b0);
    check("bge_state", state_o, 9);
    check("bge_pc_wr", PC_wr, 0);
    tick();
    check("bge_back_fetch", state_o, 0);
    lt_i = 1'b0;

    // bltu: legal on dut, trap on the no-extension copy
    do_reset();
    ltu_i = 1'b1;
    go(OP_BRANCH, 3'b110, 1'b0);
    check("bltu_pc_wr", PC_wr, 1);
    check("bltu_nx_state", nx_state, 9);
    check("bltu_nx_pc_wr", nx_PC_wr, 0);
    tick();
    check("bltu_back_fetch", state_o, 0);
    check("bltu_nx_trap", nx_state, 15);
    check("bltu_nx_illegal", nx_illegal, 1);
    ltu_i = 1'b0;

    // jalr
    go(OP_JALR, 3'b000, 1'b0);
    check("jalr_adr_state", state_o, 10);
    check("jalr_imm_src", imm_src, 2'b00);
    tick();
    check("jal_state", state_o, 11);
    check("jal_pc_wr", PC_wr, 1);
    check("jal_srcs", {ALU_src_a, ALU_src_b, result_src}, 6'b011000);
    tick();
    check("jal_wb_state", state_o, 8);
    tick();

    // illegal funct3 in EXEC_R
    go(OP_R, 3'b001, 1'b0);
    check("rbad_exec_state", state_o, 6);
    tick();
    check("rbad_trap", state_o, 15);
    do_reset();

    // illegal opcode: trap is sticky for 10 cycles
    go(7'b0000000, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("trap%0d_state", i), state_o, 15);
      check($sformatf("trap%0d_illegal", i), illegal_o, 1);
      check($sformatf("trap%0d_enables", i),
            {PC_wr, IR_wr, mem_rd, mem_wr, reg_wr}, 5'b00000);
      tick();
    end
    rst = 1'b1;
    #1;
    check("trap_rst_ir_wr", IR_wr, 0);
    tick();
    check("trap_rst_state", state_o, 0);
    check("trap_rst_illegal", illegal_o, 0);
    rst = 1'b0;

    // reset in the middle of a stalled store
    go(OP_STORE, 3'b010, 1'b0);
    check("st_imm_src", imm_src, 2'b01);
    tick();
    mem_ready_i = 1'b0;
    #1;
    check("st_wr_state", state_o, 5);
    check("st_wr_en", {mem_wr, adr_src}, 2'b11);
    tick();
    check("st_hold_state", state_o, 5);
    rst = 1'b1;
    tick();
    check("st_rst_state", state_o, 0);
    check("st_rst_mem_wr", mem_wr, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3, ALU_ctrl width (min 3); codes zero-extended.
REQ-002 SHALL have parameter EXT_BRANCH, default 1: 1 = blt/bge/bltu/bgeu legal; 0 = illegal.
REQ-003 SHALL have ports (clock and reset first), one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_i  in  7  opcode from instruction register.
- funct3_i  in  3  funct3.
- funct7_i  in  1  instruction bit 30.
- zero  in  1  ALU result == 0.
- lt_i / ltu_i  in  1 each  signed / unsigned rs1<rs2.
- mem_ready_i  in  1  memory access completes this cycle.
- PC_wr, IR_wr, adr_src, mem_rd, mem_wr, reg_wr  out  1 each.
- ALU_src_a, ALU_src_b, result_src, imm_src  out  2 each.
- ALU_ctrl  out  ALU_CTRL_W.
- state_o  out  4  current state; illegal_o  out  1  sticky trap flag.

Function
REQ-004 SHALL be a Moore FSM; state_o encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JALR_ADR 10, JAL 11, TRAP 15; codes 12-14 unreachable and go to TRAP.
REQ-005 SHALL drive every output not listed for a state to 0.
REQ-006 SHALL use ALU_ctrl codes: and 001, or 010, add 011, sub 100, slt 101, xor 110.
REQ-007 FETCH SHALL drive: mem_rd=1, adr_src=0, src_a=00, src_b=10, add, result_src=10, IR_wr=PC_wr=mem_ready_i. Leave to DECODE only when mem_ready_i=1; otherwise hold.
REQ-008 DECODE SHALL drive src_a=01, src_b=01, add. Next state by op_i:
- 0000011/0100011 -> MEM_ADR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR_ADR
- any other -> TRAP
REQ-009 MEM_ADR SHALL drive src_a=10, src_b=01, add; next MEM_RD (load) or MEM_WR (store).
REQ-010 MEM_RD SHALL drive mem_rd=1, adr_src=1; advance to MEM_WB only when mem_ready_i=1, else hold.
REQ-011 MEM_WB SHALL drive result_src=01, reg_wr=1; next FETCH.
REQ-012 MEM_WR SHALL drive mem_wr=1, adr_src=1; advance to FETCH only when mem_ready_i=1, else hold.
REQ-013 EXEC_R SHALL drive src_a=10, src_b=00. funct3 000 -> add if funct7_i=0, sub if funct7_i=1; 010 slt; 100 xor; 110 or; 111 and. Next ALU_WB; other funct3 -> TRAP.
REQ-014 EXEC_I SHALL drive src_a=10, src_b=01 with the same funct3 map, except 000 is always add; next ALU_WB; illegal funct3 -> TRAP.
REQ-015 ALU_WB SHALL drive result_src=00, reg_wr=1; next FETCH.
REQ-016 BRANCH SHALL drive src_a=10, src_b=00, sub, result_src=00, and PC_wr=taken; next FETCH. Taken conditions:
- beq: zero
- bne: !zero
- blt: lt_i; bge: !lt_i
- bltu: ltu_i; bgeu: !ltu_i
- funct3 010/011, or 100-111 with EXT_BRANCH=0 -> TRAP, PC_wr=0.
REQ-017 JALR_ADR SHALL drive src_a=10, src_b=01, add; next JAL.
REQ-018 JAL SHALL drive src_a=01, src_b=10, add, result_src=00, PC_wr=1; next ALU_WB.
REQ-019 TRAP SHALL assert illegal_o=1 and keep all write enables 0; it leaves TRAP only on rst.
REQ-020 imm_src SHALL be combinational from op_i in every state:
- I-type (0010011/0000011/1100111): 00
- S: 01
- B: 10
- all else: 11

Reset
REQ-021 rst=1 at a rising edge SHALL force state FETCH and illegal_o=0, overriding any state including mid-access waits and TRAP.
REQ-022 While held in reset, outputs SHALL equal FETCH decoding, except IR_wr=PC_wr=0 regardless of mem_ready_i.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- add: op 0110011, f3 000, f7 0, mem_ready=1 -> states 0,1,6,8,0; ALU_ctrl 011 in EXEC_R; reg_wr=1 only in ALU_WB.
- load with wait: op 0000011, mem_ready low 3 cycles in MEM_RD -> state 3 held 4 cycles with mem_rd=1, adr_src=1; then MEM_WB with result_src=01.
- branches: bne with zero=0 -> PC_wr=1 in BRANCH; bge with lt_i=1 -> PC_wr=0; bltu with EXT_BRANCH=0 -> TRAP, illegal_o=1.
- jalr: op 1100111 -> states 0,1,10,11,8; PC_wr=1 in JAL; imm_src=00.
- illegal: op 0000000 in DECODE -> TRAP, held 10 cycles with all enables 0; then rst -> FETCH, illegal_o=0.
- reset mid-store: rst during MEM_WR with mem_ready=0 -> next cycle FETCH, mem_wr=0.
